seq_multiplier_8bit: RTL and testbench

SEQ_MULTIPLIER_8BIT -- requirements
Module: seq_multiplier_8bit

---
 rtl/seq_multiplier_8bit_if.sv | 19 +
 rtl/seq_multiplier_8bit.sv | 150 +++++++++++++++
 tb/tb_seq_multiplier_8bit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_8bit_if.sv
// rtl/seq_multiplier_8bit_if.sv - request/result bundle of the sequential 8x8 multiplier
//
// Signals:
//   start  request to begin a multiply (from master)
//   a, b   unsigned 8-bit operands, captured with an accepted start (from master)
//   busy   operation in progress, CALC or DONE (from slave)
//   done   one-cycle completion pulse (from slave)
//   p      16-bit product register (from slave)
interface seq_multiplier_8bit_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  modport master (output start, output a, output b, input busy, input done, input p);
  modport slave  (input start, input a, input b, output busy, output done, output p);
endinterface

// File: rtl/seq_multiplier_8bit.sv
// rtl/seq_multiplier_8bit.sv - shift-and-add 8x8 unsigned multiplier, one bit per clock
//
// seq_multiplier_8bit ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   bus    seq_multiplier_8bit_if.slave: start/a/b in, busy/done/p out
//
// seq_multiplier_8bit_cla8 ports:
//   x, y   8-bit addends
//   cin    carry in
//   sum    8-bit sum
//   cout   carry out

module seq_multiplier_8bit_cla8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] pr;
  logic [8:0] c;
  logic       run;

  // Every carry is a flat sum of products of g/p terms and cin, so no carry
  // depends on a lower carry signal: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    g    = x & y;
    pr   = x ^ y;
    c    = '0;
    run  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      run    = pr[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & pr[j];
      end
      c[i+1] = c[i+1] | (run & cin);
    end
  end

  assign sum  = pr ^ c[7:0];
  assign cout = c[8];
endmodule

module seq_multiplier_8bit (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_multiplier_8bit_if.slave        bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  mcand;
  logic [7:0]  mq;
  logic [7:0]  acc;
  logic [2:0]  count;
  logic [15:0] prod;
  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        c;
  logic        busy;
  logic        done;

  // Gating the multiplicand with mq[0] makes the no-add case acc + 0,
  // which yields {0, acc} through the same adder.
  assign addend = mcand & {8{mq[0]}};

  seq_multiplier_8bit_cla8 u_add (
    .x    (acc),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (count == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      mq    <= '0;
      acc   <= '0;
      count <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            count <= '0;
          end
        end
        CALC: begin
          // The carry lands in acc[7], so 0xFF*0xFF never loses a bit.
          acc   <= {c, sum[7:1]};
          mq    <= {sum[0], mq[7:1]};
          count <= count + 3'd1;
          if (count == 3'd7) begin
            prod <= {c, sum, mq[7:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.p    = prod;
endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// tb/tb_seq_multiplier_8bit.sv - directed and sweep bench for seq_multiplier_8bit
module tb_seq_multiplier_8bit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  localparam int NOPS = 2256;
  logic [7:0] opa [0:NOPS-1];
  logic [7:0] opb [0:NOPS-1];

  always #5 clk = ~clk;

  seq_multiplier_8bit_if mif ();

  seq_multiplier_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mif.start = 1'b0;
    mif.a = 8'h00;
    mif.b = 8'h00;
    tick;
    tick;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    n_cmp++; if (mif.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", mif.done); end
    n_cmp++; if (mif.p !== 16'h0000) begin n_bad++; $display("FAIL reset_p: got %h want 0000", mif.p); end
    rst_n = 1'b1;
    tick;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", mif.busy); end
  endtask

  task automatic do_mult(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string nm);
    logic [15:0] old;
    int lat;
    bit held;
    old = mif.p;
    held = 1'b1;
    lat = 0;
    mif.a = x;
    mif.b = y;
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    mif.a = ~x;
    mif.b = y + 8'd77;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (mif.done === 1'b1) begin
        lat = i;
        break;
      end
      if (mif.p !== old) held = 1'b0;
    end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL %s_latency: got %0d want 8", nm, lat); end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL %s_p_hold: got changed want %h held", nm, old); end
    n_cmp++; if (mif.p !== exp) begin n_bad++; $display("FAIL %s_p: got %h want %h", nm, mif.p, exp); end
    tick;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got busy %b want 0", nm, mif.busy); end
  endtask

  task automatic test_basic;
    int nbusy;
    int ndone;
    int done_at;
    nbusy = 0;
    ndone = 0;
    done_at = -1;
    mif.a = 8'd13;
    mif.b = 8'd11;
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick;
      if (mif.busy === 1'b1) nbusy++;
      if (mif.done === 1'b1) begin
        ndone++;
        done_at = i;
        n_cmp++; if (mif.p !== 16'h008F) begin n_bad++; $display("FAIL basic_p: got %h want 008f", mif.p); end
      end
    end
    n_cmp++; if (nbusy != 9) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 9", nbusy); end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL basic_done_cycles: got %0d want 1", ndone); end
    n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL basic_done_edge: got %0d want 8", done_at); end
    n_cmp++; if (mif.p !== 16'h008F) begin n_bad++; $display("FAIL basic_p_after: got %h want 008f", mif.p); end
  endtask

  task automatic test_vectors;
    do_mult(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    do_mult(8'h00, 8'h5A, 16'h0000, "00_5a");
    do_mult(8'h80, 8'h02, 16'h0100, "80_02");
    do_mult(8'h01, 8'hFF, 16'h00FF, "01_ff");
  endtask

  task automatic test_start_ignored;
    int lat;
    lat = 0;
    mif.a = 8'd13;
    mif.b = 8'd11;
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    tick;
    tick;
    tick;
    mif.a = 8'hFF;
    mif.b = 8'hFF;
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    for (int i = 5; i <= 20; i++) begin
      tick;
      if (mif.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL ignore_calc_latency: got %0d want 8", lat); end
    n_cmp++; if (mif.p !== 16'h008F) begin n_bad++; $display("FAIL ignore_calc_p: got %h want 008f", mif.p); end
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_done_busy: got %b want 0", mif.busy); end
    tick;
    tick;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_not_queued: got busy %b want 0", mif.busy); end
    n_cmp++; if (mif.p !== 16'h008F) begin n_bad++; $display("FAIL ignore_p_kept: got %h want 008f", mif.p); end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    saw_done = 1'b0;
    mif.a = 8'hFF;
    mif.b = 8'hFF;
    mif.start = 1'b1;
    tick;
    mif.start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", mif.busy); end
    n_cmp++; if (mif.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", mif.done); end
    n_cmp++; if (mif.p !== 16'h0000) begin n_bad++; $display("FAIL rstmid_p: got %h want 0000", mif.p); end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (mif.done === 1'b1 || mif.busy === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL rstmid_abandoned: got activity want none"); end
    rst_n = 1'b0;
    mif.a = 8'd3;
    mif.b = 8'd5;
    mif.start = 1'b1;
    tick;
    rst_n = 1'b1;
    mif.start = 1'b0;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_over_start: got busy %b want 0", mif.busy); end
    tick;
    n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_over_start_2: got busy %b want 0", mif.busy); end
    do_mult(8'd3, 8'd5, 16'h000F, "3_5");
  endtask

  task automatic test_back_to_back;
    int lat;
    int last_done;
    logic [15:0] exp;
    last_done = -1;
    for (int k = 0; k < NOPS; k++) begin
      if (k < 256) begin
        opa[k] = 8'hFF;
        opb[k] = 8'(k);
      end else begin
        opa[k] = 8'($urandom_range(0, 255));
        opb[k] = 8'($urandom_range(0, 255));
      end
    end
    mif.a = opa[0];
    mif.b = opb[0];
    mif.start = 1'b1;
    for (int k = 0; k < NOPS; k++) begin
      tick;
      n_cmp++; if (mif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d]: got busy %b want 1", k, mif.busy); end
      if (k + 1 < NOPS) begin
        mif.a = opa[k+1];
        mif.b = opb[k+1];
      end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        tick;
        if (mif.done === 1'b1) begin
          lat = i;
          break;
        end
      end
      exp = {8'h00, opa[k]} * {8'h00, opb[k]};
      n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want 8", k, lat); end
      n_cmp++; if (mif.p !== exp) begin n_bad++; $display("FAIL b2b_p[%0d] %h*%h: got %h want %h", k, opa[k], opb[k], mif.p, exp); end
      if (last_done >= 0) begin
        n_cmp++; if (cyc - last_done != 10) begin n_bad++; $display("FAIL b2b_period[%0d]: got %0d want 10", k, cyc - last_done); end
      end
      last_done = cyc;
      tick;
      n_cmp++; if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle[%0d]: got busy %b want 0", k, mif.busy); end
    end
    mif.start = 1'b0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
